// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that owns the HI and LO registers.
//   Executes mult/multu/div/divu in WIDTH iterations plus one fix-up cycle and
//   services mthi/mtlo writes while idle.
// Ports:
//   clk, reset (sync, active-high), clk_enable (freezes every register when low)
//   start, op[1:0] (00 mult, 01 multu, 10 div, 11 divu), op_a, op_b
//   hi_write, lo_write, wdata : mthi / mtlo path
//   busy, done (one-cycle pulse), div_by_zero (qualifies done), hi, lo
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hi_write,
   input  logic             lo_write,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    counter_q, counter_d;
   logic [1:0]       op_q, op_d;
   // multiplicand (mult) or divisor (div), already made non-negative
   logic [WIDTH-1:0] opnd_q, opnd_d;
   // mult: product upper half; div: partial remainder
   logic [WIDTH:0]   rem_q, rem_d;
   // mult: multiplier shifting out / product lower half; div: dividend shifting out / quotient
   logic [WIDTH-1:0] quo_q, quo_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic             sign_a_s, sign_b_s;
   logic [WIDTH-1:0] abs_a_s, abs_b_s;
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH:0]   div_shift_s;
   logic [WIDTH+1:0] div_diff_s;
   logic [2*WIDTH-1:0] prod_s, prod_fix_s;
   logic [WIDTH-1:0] quo_fix_s, rem_fix_s;
   logic             div_zero_s;

   // Next-state, datapath step and HI/LO update logic
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      op_d      = op_q;
      opnd_d    = opnd_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dbz_d     = dbz_q;

      // only signed ops (op[0]==0) take magnitudes
      sign_a_s = ~op[0] & op_a[WIDTH-1];
      sign_b_s = ~op[0] & op_b[WIDTH-1];
      abs_a_s  = sign_a_s ? -op_a : op_a;
      abs_b_s  = sign_b_s ? -op_b : op_b;

      // shift-add: add multiplicand into upper half when multiplier LSB is set, then shift right
      mul_sum_s = {1'b0, rem_q[WIDTH-1:0]}
                + {1'b0, (quo_q[0] ? opnd_q : {WIDTH{1'b0}})};
      // restoring divide: the extra top bit of the difference is the borrow
      div_shift_s = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_q};

      prod_s     = {rem_q[WIDTH-1:0], quo_q};
      prod_fix_s = neg_res_q ? -prod_s : prod_s;
      quo_fix_s  = neg_res_q ? -quo_q : quo_q;
      rem_fix_s  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      div_zero_s = (opnd_q == {WIDTH{1'b0}});

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RUN;
               counter_d = CW'(WIDTH - 1);
               op_d      = op;
               busy_d    = 1'b1;
               neg_res_d = sign_a_s ^ sign_b_s;
               neg_rem_d = sign_a_s;
               rem_d     = {(WIDTH+1){1'b0}};
               if (op[1]) begin
                  opnd_d = abs_b_s;
                  quo_d  = abs_a_s;
               end else begin
                  opnd_d = abs_a_s;
                  quo_d  = abs_b_s;
               end
            end else begin
               hi_d = hi_write ? wdata : hi_q;
               lo_d = lo_write ? wdata : lo_q;
            end
         end
         S_RUN: begin
            if (op_q[1]) begin
               if (!div_diff_s[WIDTH+1]) begin
                  rem_d = div_diff_s[WIDTH:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = div_shift_s;
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               rem_d = {1'b0, 1'b0, mul_sum_s[WIDTH:1]};
               quo_d = {mul_sum_s[0], quo_q[WIDTH-1:1]};
            end
            counter_d = counter_q - CW'(1);
            if (counter_q == {CW{1'b0}}) begin
               state_d = S_FIX;
            end else begin
               state_d = S_RUN;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (op_q[1]) begin
               // With a zero divisor the remainder is |op_a|; undoing its sign
               // restores the original dividend for hi.
               hi_d = rem_fix_s;
               if (div_zero_s) begin
                  lo_d  = {WIDTH{1'b1}};
                  dbz_d = 1'b1;
               end else begin
                  lo_d  = quo_fix_s;
                  dbz_d = 1'b0;
               end
            end else begin
               hi_d  = prod_fix_s[2*WIDTH-1:WIDTH];
               lo_d  = prod_fix_s[WIDTH-1:0];
               dbz_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers: reset and updates both gated by clk_enable
   always_ff @(posedge clk) begin
      if (clk_enable) begin
         if (reset) begin
            state_q   <= S_IDLE;
            counter_q <= {CW{1'b0}};
            op_q      <= 2'b00;
            opnd_q    <= {WIDTH{1'b0}};
            rem_q     <= {(WIDTH+1){1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
         end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
         end
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Parametrised, iterative multiply/divide unit that owns the CPU's HI and LO registers.
- Executes mult, multu, div and divu over WIDTH cycles and services mthi/mtlo writes.
- Exposes a start/busy/done handshake so the CPU core stalls on mfhi/mflo while an operation is in flight.
- Sits beside the ALU in the Harvard core and replaces the single-cycle HI/LO path.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; even, >= 4
- CW, $clog2(WIDTH), iteration counter width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; acts only when clk_enable is high, like all other state
- clk_enable  input  1  global clock enable; when low, all registers hold
- start  input  1  begin operation; sampled in IDLE only
- op  input  2  00 mult, 01 multu, 10 div, 11 divu
- op_a  input  WIDTH  multiplicand / dividend (rs)
- op_b  input  WIDTH  multiplier / divisor (rt)
- hi_write  input  1  mthi strobe
- lo_write  input  1  mtlo strobe
- wdata  input  WIDTH  data for mthi/mtlo
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO updated by an operation
- div_by_zero  output  1  qualifies done; divisor was zero
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- Reset:
  - state IDLE
  - busy=0, done=0, div_by_zero=0
  - hi=0, lo=0, counter=0
- States:
  - IDLE
  - RUN: WIDTH iterations, counter WIDTH-1 down to 0
  - FIX: sign correction and HI/LO write
- IDLE → RUN on start:
  - Latch op.
  - Latch |op_a| and |op_b| for signed ops, raw values for unsigned.
  - Latch result-sign flags: quotient/product sign = sign_a ^ sign_b; remainder sign = sign_a.
- Multiply, per RUN cycle: shift-add radix-2 into a 2*WIDTH accumulator, LSB-first on the multiplier.
- Divide, per RUN cycle: restoring shift-subtract; remainder WIDTH+1 bits, quotient bit shifted into LSB.
- RUN → FIX when counter = 0.
- FIX → IDLE unconditionally. In FIX:
  - Negate the product or quotient/remainder as flagged (two's complement, WIDTH-bit wrap).
  - Write hi = product[2W-1:W], lo = product[W-1:0] (mult), or hi = remainder, lo = quotient (div).
  - Register done=1 for exactly one cycle.
- Division semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divisor zero (div or divu): lo = all ones, hi = op_a as latched (unnegated original), div_by_zero=1 with done.
  - Signed most-negative / -1: lo = most-negative, hi = 0, no flag.
- mthi/mtlo:
  - In IDLE with start low, hi_write loads hi from wdata at the edge; likewise lo_write loads lo; both may fire together.
  - Ignored while busy.
  - Ignored in the same cycle as start (start has priority).
- start while busy: ignored; no queuing.
- div_by_zero holds its value until the next done or reset.

## Timing
- start sampled at edge t0:
  - busy=1 after t0.
  - RUN iterations occupy edges t1..tWIDTH.
  - FIX resolves at edge t(WIDTH+1): hi/lo valid, done=1, busy=0 after that edge.
- Latency from start edge to visible result: WIDTH+1 cycles. busy is high for WIDTH+1 cycles.
- done is high for exactly the cycle following t(WIDTH+1). A new start may be sampled in that same cycle.
- hi/lo are registered outputs and never change combinationally. mthi/mtlo results are visible one cycle after the strobe.
- clk_enable low for any cycles: state, counter, accumulators and outputs freeze. done stays high if already high. The cycle count resumes with no skipped iteration.
- reset mid-operation (clk_enable high): next edge forces the full reset state. The partial result is discarded and hi/lo = 0.

## Test plan
- WIDTH=32, mult op_a=FFFFFFFF op_b=00000002 → done after 33 cycles; hi=FFFFFFFF, lo=FFFFFFFE. Same operands with multu → hi=00000001, lo=FFFFFFFE.
- div op_a=FFFFFFF9 (-7) op_b=00000002 → lo=FFFFFFFD, hi=FFFFFFFF. div 80000000 / FFFFFFFF → lo=80000000, hi=0, div_by_zero=0.
- divu op_a=00000064 op_b=0 → lo=FFFFFFFF, hi=00000064, div_by_zero=1 with the done pulse.
- Start multu 3*5. At cycle 10 pulse start again (div 1/1) together with hi_write wdata=DEADBEEF → both ignored. Final hi=0, lo=0000000F, single done pulse.
- Start divu 1000/7. Assert reset at cycle 12 → next edge busy=0, hi=lo=0, no done ever. Then a clean mthi wdata=12345678 → hi=12345678 one cycle later.
- Start mult 3*-4 and drop clk_enable for 5 cycles mid-RUN → done arrives exactly 5 cycles late; hi=FFFFFFFF, lo=FFFFFFF4. Also run WIDTH=8: multu FF*FF → hi=FE, lo=01, latency 9 cycles.
